// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Five-state multicycle CPU controller (FETCH/DECODE/EXEC/MEM/WB)
//            with a memory handshake and a multi-cycle MUL hold in EXEC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
    parameter int OP_W       = 4,
    parameter int FN_W       = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [OP_W-1:0] OPCODE,
    input  logic [FN_W-1:0] FUNCT,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            Branch,
    output logic            AluSrcA,
    output logic [1:0]      AluSrcB,
    output logic [1:0]      AluOp,
    output logic [2:0]      State,
    output logic            InstrDone,
    output logic            IllegalOp
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LS   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SS   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6);
    localparam logic [FN_W-1:0] FN_MUL  = FN_W'(5);

    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [OP_W-1:0] op_q;
    logic [FN_W-1:0] fn_q;
    logic [CNT_W-1:0] mul_cnt;

    logic live_legal;
    logic is_addi, is_ls, is_ss, is_beq, is_r, is_mul;

    // DECODE judges legality on the live opcode; later states only see the latch.
    assign live_legal = (OPCODE == OP_ADDI) || (OPCODE == OP_LS) || (OPCODE == OP_SS) ||
                        (OPCODE == OP_BEQ)  || (OPCODE == OP_R);

    assign is_addi = (op_q == OP_ADDI);
    assign is_ls   = (op_q == OP_LS);
    assign is_ss   = (op_q == OP_SS);
    assign is_beq  = (op_q == OP_BEQ);
    assign is_r    = (op_q == OP_R);
    assign is_mul  = is_r && (fn_q == FN_MUL);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            mul_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_q <= OPCODE;
                fn_q <= FUNCT;
            end
            if ((state == S_EXEC) && (state_next == S_EXEC)) begin
                mul_cnt <= mul_cnt + CNT_W'(1);
            end else begin
                mul_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        AluOp      = 2'b00;
        InstrDone  = 1'b0;
        IllegalOp  = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                AluSrcB    = 2'b01;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                state_next = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                AluSrcB = 2'b10;
                if (live_legal) begin
                    state_next = S_EXEC;
                end else begin
                    IllegalOp  = 1'b1;
                    InstrDone  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_mul) begin
                    AluSrcA    = 1'b1;
                    AluOp      = 2'b11;
                    state_next = (mul_cnt == CNT_LAST) ? S_WB : S_EXEC;
                end else if (is_r) begin
                    AluSrcA    = 1'b1;
                    AluOp      = 2'b10;
                    state_next = S_WB;
                end else if (is_addi || is_ls || is_ss) begin
                    AluSrcA    = 1'b1;
                    AluSrcB    = 2'b10;
                    state_next = is_addi ? S_WB : S_MEM;
                end else if (is_beq) begin
                    AluSrcA    = 1'b1;
                    AluOp      = 2'b01;
                    Branch     = 1'b1;
                    PCWrite    = Zero;
                    InstrDone  = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                MemRead  = is_ls;
                MemWrite = is_ss;
                if (!(is_ls || is_ss)) begin
                    state_next = S_FETCH;
                end else if (!MemReady) begin
                    state_next = S_MEM;
                end else if (is_ls) begin
                    state_next = S_WB;
                end else begin
                    InstrDone  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                RegDst     = is_r;
                MemToReg   = is_ls;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign State = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Scoreboard bench: per-instruction expectations from an abstract
//            model, checked by a monitor whenever InstrDone is presented.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    localparam int MC = 3;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] OPCODE, FUNCT;
    logic       Zero, MemReady;
    logic       PCWrite, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, Branch, AluSrcA;
    logic [1:0] AluSrcB, AluOp;
    logic [2:0] State;
    logic       InstrDone, IllegalOp;

    logic       r5, z5, mr5;
    logic [3:0] op5, fn5;
    logic       m5_pcw, m5_irw, m5_mrd, m5_mwr, m5_m2r, m5_rdst, m5_rw, m5_br, m5_asa;
    logic [1:0] m5_asb, m5_aop;
    logic [2:0] m5_state;
    logic       m5_done, m5_ill;

    always #5 Clock = ~Clock;

    multicycle_control_unit #(.OP_W(4), .FN_W(4), .MUL_CYCLES(MC)) dut (
        .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .Branch(Branch), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
        .State(State), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
    );

    multicycle_control_unit #(.OP_W(4), .FN_W(4), .MUL_CYCLES(5)) dut5 (
        .Clock(Clock), .Reset(r5), .OPCODE(op5), .FUNCT(fn5), .Zero(z5),
        .MemReady(mr5), .PCWrite(m5_pcw), .IRWrite(m5_irw), .MemRead(m5_mrd),
        .MemWrite(m5_mwr), .MemToReg(m5_m2r), .RegDst(m5_rdst), .RegWrite(m5_rw),
        .Branch(m5_br), .AluSrcA(m5_asa), .AluSrcB(m5_asb), .AluOp(m5_aop),
        .State(m5_state), .InstrDone(m5_done), .IllegalOp(m5_ill)
    );

    typedef struct {
        int          lat;
        logic [63:0] trace;
        int          mulc, rw, mw, mrd, br, pcw, ill, irw;
        int          regdst, memtoreg;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected instruction behaviour: the visited state sequence and how many
    // cycles each control was active, given fetch/memory stall counts.
    function automatic exp_t model(input logic [3:0] op, input logic [3:0] fn,
                                   input int f, input int m, input bit z);
        exp_t e;
        bit addi, ls, ss, beq, r, mul, legal;
        e = '{lat: 0, trace: '0, mulc: 0, rw: 0, mw: 0, mrd: 0, br: 0, pcw: 0,
              ill: 0, irw: 0, regdst: 0, memtoreg: 0};
        addi = (op == 4'd1); ls = (op == 4'd2); ss = (op == 4'd3);
        beq  = (op == 4'd4); r  = (op == 4'd6); mul = r && (fn == 4'd5);
        legal = addi || ls || ss || beq || r;
        for (int i = 0; i <= f; i++) begin e.trace = e.trace << 3; e.lat++; end
        e.trace = (e.trace << 3) | 64'd1; e.lat++;
        e.irw = 1;
        e.pcw = 1;
        if (!legal) begin
            e.ill = 1;
        end else begin
            for (int i = 0; i < (mul ? MC : 1); i++) begin
                e.trace = (e.trace << 3) | 64'd2; e.lat++;
            end
            e.mulc = mul ? MC : 0;
            if (ls || ss) begin
                for (int i = 0; i <= m; i++) begin e.trace = (e.trace << 3) | 64'd3; e.lat++; end
                e.mw  = ss ? m + 1 : 0;
                e.mrd = ls ? m + 1 : 0;
            end
            if (beq) begin
                e.br  = 1;
                e.pcw = 1 + int'(z);
            end
            if (!(beq || ss)) begin
                e.trace = (e.trace << 3) | 64'd4; e.lat++;
                e.rw = 1;
                e.regdst = int'(r);
                e.memtoreg = int'(ls);
            end
        end
        return e;
    endfunction

    int          a_cyc, a_mul, a_rw, a_mw, a_mrd, a_br, a_pcw, a_ill, a_irw;
    logic [63:0] a_trace;

    task automatic clear_acc();
        a_cyc = 0; a_mul = 0; a_rw = 0; a_mw = 0; a_mrd = 0;
        a_br = 0; a_pcw = 0; a_ill = 0; a_irw = 0; a_trace = '0;
    endtask

    always @(negedge Clock) begin
        #1;
        if (mon_en) begin
            if (Reset) begin
                clear_acc();
            end else begin
                a_cyc++;
                a_trace = (a_trace << 3) | 64'(State);
                a_mul += int'(AluOp == 2'b11);
                a_rw  += int'(RegWrite);
                a_mw  += int'(MemWrite);
                a_mrd += int'(MemRead && State == 3'd3);
                a_br  += int'(Branch);
                a_pcw += int'(PCWrite);
                a_ill += int'(IllegalOp);
                a_irw += int'(IRWrite);
                check("regwrite_outside_wb", longint'(RegWrite && State != 3'd4), 0);
                if (State == 3'd0) begin
                    check("fetch_irwrite", longint'(IRWrite), longint'(MemReady));
                    check("fetch_memread", longint'(MemRead), 1);
                    check("fetch_alusrcb", longint'(AluSrcB), 1);
                end
                if (InstrDone) begin
                    if (sb.size() == 0) begin
                        check("unexpected_instrdone", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("latency",   a_cyc, e.lat);
                        check("state_seq", longint'(a_trace), longint'(e.trace));
                        check("mul_cycles", a_mul, e.mulc);
                        check("regwrite",  a_rw,  e.rw);
                        check("memwrite",  a_mw,  e.mw);
                        check("mem_read",  a_mrd, e.mrd);
                        check("branch",    a_br,  e.br);
                        check("pcwrite",   a_pcw, e.pcw);
                        check("illegalop", a_ill, e.ill);
                        check("irwrite",   a_irw, e.irw);
                        check("regdst",    longint'(RegDst),   e.regdst);
                        check("memtoreg",  longint'(MemToReg), e.memtoreg);
                    end
                    clear_acc();
                end
            end
        end
    end

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn,
                             input int f, input int m, input bit z);
        int fw = 0;
        int mw = 0;
        bit done = 0;
        sb.push_back(model(op, fn, f, m, z));
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge Clock);
            if (c == 0) begin
                Reset = 1'b0; OPCODE = op; FUNCT = fn; Zero = z;
            end else if (State >= 3'd2) begin
                OPCODE = 4'($urandom); FUNCT = 4'($urandom);
            end
            if (State == 3'd0) begin
                MemReady = (fw >= f); if (!MemReady) fw++;
            end else if (State == 3'd3) begin
                MemReady = (mw >= m); if (!MemReady) mw++;
            end else begin
                MemReady = 1'($urandom);
            end
            #2;
            if (InstrDone) done = 1;
        end
        if (!done) check("instr_timeout", 0, 1);
    endtask

    task automatic run_reset(input logic [3:0] op, input logic [3:0] fn);
        int seen = 0;
        bit hit = 0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge Clock);
            if (c == 0) begin
                Reset = 1'b0; OPCODE = op; FUNCT = fn; Zero = 1'b0;
            end
            MemReady = (State != 3'd3);
            if (State == 3'd2 && op == 4'd6) seen++;
            if (State == 3'd3) seen++;
            if (seen == 2) begin Reset = 1'b1; hit = 1; end
        end
        if (!hit) check("reset_case_timeout", 0, 1);
        @(negedge Clock);
        #2;
        check("rst_state",    longint'(State), 0);
        check("rst_memwrite", longint'(MemWrite), 0);
        check("rst_aluop",    longint'(AluOp), 0);
        check("rst_done",     longint'(InstrDone), 0);
    endtask

    initial begin
        int lat5, alu5, rdst5, rw5;
        bit done5;
        Reset = 1'b1; OPCODE = '0; FUNCT = '0; Zero = 1'b0; MemReady = 1'b0;
        r5 = 1'b1; op5 = 4'd6; fn5 = 4'd5; z5 = 1'b0; mr5 = 1'b1;
        clear_acc();
        repeat (2) @(negedge Clock);
        #2;
        check("reset_state",   longint'(State), 0);
        check("reset_memread", longint'(MemRead), 1);
        check("reset_alusrcb", longint'(AluSrcB), 1);
        check("reset_irwrite", longint'(IRWrite), 0);
        check("reset_pcwrite", longint'(PCWrite), 0);
        check("reset_others",  longint'({MemWrite, MemToReg, RegDst, RegWrite, Branch,
                                         AluSrcA, AluOp, InstrDone, IllegalOp}), 0);
        MemReady = 1'b1;
        #1;
        check("reset_irwrite_rdy", longint'(IRWrite), 1);
        check("reset_pcwrite_rdy", longint'(PCWrite), 1);
        mon_en = 1;

        run_instr(4'd1, 4'd0, 0, 0, 0);   // ADDI
        run_instr(4'd2, 4'd0, 0, 2, 0);   // LS, two MEM stalls
        run_instr(4'd4, 4'd0, 0, 0, 1);   // BEQ taken
        run_instr(4'd4, 4'd0, 0, 0, 0);   // BEQ not taken
        run_instr(4'd6, 4'd5, 0, 0, 0);   // MUL
        run_instr(4'd6, 4'd2, 1, 0, 0);   // R
        run_instr(4'd3, 4'd0, 2, 1, 0);   // SS
        run_instr(4'hF, 4'd0, 0, 0, 0);   // illegal
        run_reset(4'd6, 4'd5);            // reset mid-MUL
        run_instr(4'd6, 4'd5, 0, 0, 0);
        run_instr(4'd1, 4'd0, 0, 0, 0);
        run_reset(4'd3, 4'd0);            // reset mid-SS wait
        run_instr(4'd1, 4'd0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op, fn;
            int k;
            k  = int'($urandom_range(0, 6));
            fn = 4'($urandom);
            case (k)
                0: op = 4'd1;
                1: op = 4'd2;
                2: op = 4'd3;
                3: op = 4'd4;
                4: begin op = 4'd6; if (fn == 4'd5) fn = 4'd0; end
                5: begin op = 4'd6; fn = 4'd5; end
                default: begin
                    op = 4'($urandom);
                    while (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6}) op = 4'($urandom);
                end
            endcase
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom));
        end
        check("scoreboard_drained", sb.size(), 0);
        mon_en = 0;
        @(negedge Clock);
        MemReady = 1'b0;

        // MUL on the MUL_CYCLES=5 instance, opcode scrambled once EXEC begins
        lat5 = 0; alu5 = 0; rdst5 = 0; rw5 = 0; done5 = 0;
        for (int c = 0; c < 40 && !done5; c++) begin
            @(negedge Clock);
            if (c == 0) r5 = 1'b0;
            if (c >= 2) begin op5 = 4'hF; fn5 = 4'd0; end
            #1;
            lat5++;
            alu5 += int'(m5_aop == 2'b11);
            if (m5_done) begin
                done5 = 1; rdst5 = int'(m5_rdst); rw5 = int'(m5_rw);
            end
        end
        check("mul5_done",    longint'(done5), 1);
        check("mul5_latency", lat5, 8);
        check("mul5_aluop",   alu5, 5);
        check("mul5_regdst",  rdst5, 1);
        check("mul5_regwr",   rw5, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OP_W, default 4, opcode width; SHALL be >= 4, with encodings below zero-extended.
REQ-002 Parameter FN_W, default 4, funct width; SHALL be >= 4, with encodings below zero-extended.
REQ-003 Parameter MUL_CYCLES, default 3, number of EXEC cycles for MUL; SHALL be >= 1.
REQ-004 Clock  in  1  single clock; all state changes occur on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 OPCODE  in  OP_W  opcode from the instruction register.
REQ-007 FUNCT  in  FN_W  R-format function field.
REQ-008 Zero  in  1  ALU zero flag, used in BEQ EXEC.
REQ-009 MemReady  in  1  memory handshake; access completes in a cycle with MemRead or MemWrite=1 and MemReady=1.
REQ-010 PCWrite, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, Branch, AluSrcA  out  1 each  datapath controls.
REQ-011 AluSrcB  out  2  00=reg B, 01=constant 1, 10=immediate; AluOp  out  2  00=add, 01=sub/compare, 10=R-funct, 11=MUL.
REQ-012 State  out  3  current state; InstrDone  out  1  last cycle of an instruction; IllegalOp  out  1  one-cycle pulse for an unsupported opcode.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL be unreachable and SHALL go to FETCH on the next edge.
REQ-014 Opcode encodings SHALL be: ADDI=0001, LS=0010, SS=0011, BEQ=0100, R=0110; R with FUNCT=0101 SHALL be MUL.
REQ-015 In DECODE, the block SHALL latch OPCODE and FUNCT; EXEC, MEM and WB SHALL use only the latched copy.
REQ-016 Outputs SHALL be decoded from the state and latched opcode; MemReady, Zero and the MUL counter SHALL be the only other inputs to the decode; unlisted outputs SHALL be 0.
REQ-017 FETCH outputs SHALL be: MemRead=1, AluSrcB=01, AluOp=00, IRWrite=PCWrite=MemReady; the FSM SHALL stay in FETCH until MemReady=1, then go to DECODE.
REQ-018 DECODE outputs SHALL be: AluSrcB=10, AluOp=00.
REQ-019 DECODE transitions: a legal opcode SHALL go to EXEC; any other opcode SHALL pulse IllegalOp=1 and InstrDone=1, then go to FETCH.
REQ-020 EXEC controls for R: AluSrcA=1, AluSrcB=00, AluOp=10; the FSM SHALL then go to WB.
REQ-021 EXEC controls for MUL: AluSrcA=1, AluSrcB=00, AluOp=11; a counter SHALL hold EXEC for exactly MUL_CYCLES cycles, then go to WB; the counter SHALL clear on leaving EXEC.
REQ-022 EXEC controls for ADDI/LS/SS: AluSrcA=1, AluSrcB=10, AluOp=00; ADDI SHALL go to WB, and LS/SS SHALL go to MEM.
REQ-023 EXEC controls for BEQ: AluSrcA=1, AluSrcB=00, AluOp=01, Branch=1, PCWrite=Zero, InstrDone=1; the FSM SHALL then go to FETCH.
REQ-024 MEM outputs SHALL be: LS drives MemRead=1 and SS drives MemWrite=1; the FSM SHALL wait for MemReady=1, after which LS SHALL go to WB and SS SHALL assert InstrDone=1 and go to FETCH.
REQ-025 WB outputs SHALL be: RegWrite=1 and InstrDone=1; RegDst=1 for R/MUL and 0 for ADDI/LS; MemToReg=1 for LS only; the FSM SHALL then go to FETCH.
REQ-026 RegWrite SHALL never assert outside WB; MemWrite SHALL never assert outside MEM for SS; no X SHALL be driven on any output.
REQ-027 With MemReady held at 1, instruction latency SHALL be: BEQ 3; ADDI/R/SS 4; LS 5; MUL 3+MUL_CYCLES cycles.

Reset
REQ-028 When Reset=1 at an edge, the next state SHALL be FETCH, the MUL counter and latched opcode/funct SHALL be 0, and IllegalOp/InstrDone SHALL be 0; this applies in any state, including mid-MUL or mid-MEM wait.
REQ-029 After reset, outputs SHALL equal the FETCH values: MemRead=1, AluSrcB=01, IRWrite=PCWrite=MemReady, others 0, State=0.

Verification
REQ-030 ADDI (0001) with MemReady=1 -> State sequence 0,1,2,4; WB shows RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1; 4 cycles.
REQ-031 LS (0010) with MemReady low 2 cycles in MEM -> MEM held 3 cycles with MemRead=1; WB shows MemToReg=1, RegWrite=1; 7 cycles total.
REQ-032 BEQ (0100) twice, with Zero=1 then Zero=0 -> EXEC Branch=1 both times; PCWrite=1 then 0; back to FETCH after 3 cycles each.
REQ-033 MUL (0110/0101), MUL_CYCLES=3, then 5 -> AluOp=11 for exactly 3 and 5 EXEC cycles; WB RegDst=1; OPCODE changed during EXEC has no effect.
REQ-034 Opcode 1111 -> IllegalOp=1 for one DECODE cycle, InstrDone=1, no RegWrite/MemWrite, next state FETCH.
REQ-035 Reset=1 in the second MUL EXEC cycle and also during the SS MEM wait -> next cycle State=0, MemWrite=0, counter=0; a following ADDI completes normally.
